mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported unified instruction/data memory between the multicycle CPU (port 0) and a loader/debug requester (port 1). It sits between the CPU's memory address mux and the memory instance, replacing the direct `we`/`a`/`d` connection. The CPU is stalled while the loader owns the memory. Ownership is held for bursts, with round-robin tie-break and a bounded burst length so neither side starves.

## Interface
- `AW`, 16: memory address width.
- `DW`, 32: data width.
- `MAX_BURST`, 8: maximum consecutive accesses by one owner while the other port is requesting; legal range ≥ 1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `req0`, `req1` in 1 each: access request, held until the access is performed.
- `we0`, `we1` in 1 each: write enable qualifying the request.
- `addr0`, `addr1` in AW each: word address.
- `wdata0`, `wdata1` in DW each: write data.
- `gnt0`, `gnt1` out 1 each: registered ownership; one-hot or both 0.
- `rdata` out DW: registered read data, shared by both ports.
- `rvalid0`, `rvalid1` out 1 each: `rdata` valid for that port, one cycle after the access.
- `cpu_stall` out 1: `req0 & ~gnt0`.
- `mem_we` out 1, `mem_a` out AW, `mem_d` out DW: memory control, address and write data.
- `mem_spo` in DW: asynchronous memory read data.
- `acc_cnt0`, `acc_cnt1` out 16 each: access counters (see Configuration).

## Operation
- States: IDLE, OWN0, OWN1. Next-state logic is combinational; the state register is clocked.
- Priority pointer `last`, resets to 1, so port 0 wins the first tie.

**IDLE**
- Only `req0` asserted → OWN0.
- Only `req1` asserted → OWN1.
- Both asserted → port ≠ `last`.

**OWNx**
- `req_x` low → OWN_other if `req_other` is high, else IDLE.
- `req_x` high, `burst_cnt == MAX_BURST-1` and `req_other` high → OWN_other.
- Otherwise stay in OWNx.

**Access and counters**
- An access is performed in every cycle where `state == OWNx` and `req_x` is high.
- During an access: `mem_a = addr_x`, `mem_d = wdata_x`, `mem_we = we_x`.
- With no access: `mem_we = 0`, `mem_a = 0`, `mem_d = 0`.
- `burst_cnt` increments per access and clears on every state change.
- `last` updates to x on entry to OWNx.
- Read access: `rdata <= mem_spo` and `rvalid_x <= 1` for one cycle.
- Write access: `rvalid_x` stays 0.
- Handover between OWN0 and OWN1 is direct, with no IDLE bubble.

## Timing
- Reset values: state IDLE, `gnt0 = gnt1 = 0`, `rdata = 0`, `rvalid0 = rvalid1 = 0`, `mem_we = 0`, counters 0, `burst_cnt = 0`, `last = 1`.
- Grant latency: request first seen at edge N in IDLE → `gnt` high after edge N; access in cycle N+1.
- Read data latency: 1 cycle after the access cycle.
- A requester with `gnt` high completes one access per cycle.
- Request drop: when `req_x` drops, `gnt_x` deasserts after the next edge; `mem_we` is already 0 in the drop cycle.
- Reset mid-burst: the edge with `reset = 0` clears grant and `rvalid`. No write is issued in any cycle where the registered state is IDLE.
- Simultaneous burst limit and `req_x` drop: the switch to the other port happens once, with no extra cycle.

## Configuration
- `MEM_ARB_STATS_EN` defined: `acc_cnt0` and `acc_cnt1` count performed accesses per port, 16-bit, wrapping 0xFFFF→0, cleared by reset.
- Macro undefined: the counters are not instantiated and both ports are tied to 0.

## Structure
- Shared package holds:
  - state encoding: IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2;
  - the `AW`/`DW` defaults;
  - the counter width constant.
- One sub-module: `arb_burst_counter` (count, clear, limit-reached flag). Everything else is inline.

## Test plan
- Reset, then `req0=1`, `we0=0`, `addr0=0x0010`, memory word 0x1234ABCD → `gnt0` after the 1st edge; `rdata = 0x1234ABCD` with `rvalid0 = 1` after the 2nd edge.
- `req0` and `req1` both raised from IDLE after reset → OWN0 first. Repeat the tie from IDLE → OWN1 (round-robin).
- `req0` held continuously, `req1` raised at cycle 3, `MAX_BURST = 8` → exactly 8 port-0 accesses, then `gnt1`. Port 1 is granted at the first legal switch once its request is seen; `cpu_stall = 1` while `gnt1` is high.
- Loader writes 0xDEADBEEF to 0x0004, then the CPU reads 0x0004 → CPU `rdata = 0xDEADBEEF`; `mem_we` is high for exactly one cycle.
- `reset = 0` asserted mid-burst of port-1 writes → after that edge `gnt1 = 0`, `mem_we = 0`, state IDLE, counters 0.
- With `MEM_ARB_STATS_EN`: 5 port-0 reads and 3 port-1 writes → `acc_cnt0 = 5`, `acc_cnt1 = 3`. Without the macro both read 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, default bus widths and access counter width.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int DEF_AW = 16;
   localparam int DEF_DW = 32;
   localparam int CNT_W  = 16;

endpackage

// File: rtl/arb_burst_counter.sv
// Counts accesses in the current ownership burst and flags the limit.
// Saturates at MAX_BURST-1 so a long solo burst hands over promptly.
module arb_burst_counter #(
   parameter int MAX_BURST = 8,
   localparam int BW = $clog2(MAX_BURST) + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   logic [BW-1:0] count;

   assign at_limit = (count == BW'(MAX_BURST - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter sharing one memory between the CPU (port 0) and a loader.
// Define MEM_ARB_STATS_EN to build the per-port access counters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MAX_BURST = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [AW-1:0]    addr0,
   input  logic [AW-1:0]    addr1,
   input  logic [DW-1:0]    wdata0,
   input  logic [DW-1:0]    wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [DW-1:0]    rdata,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic             cpu_stall,
   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   output logic [DW-1:0]    mem_d,
   input  logic [DW-1:0]    mem_spo,
   output logic [CNT_W-1:0] acc_cnt0,
   output logic [CNT_W-1:0] acc_cnt1
);

   arb_state_t state;
   arb_state_t next_state;
   logic       last;
   logic       acc0;
   logic       acc1;
   logic       at_limit;
   logic       state_chg;

   assign acc0      = (state == OWN0) && req0;
   assign acc1      = (state == OWN1) && req1;
   assign state_chg = (next_state != state);
   assign cpu_stall = req0 & ~gnt0;

   arb_burst_counter #(
      .MAX_BURST(MAX_BURST)
   ) u_burst (
      .clk      (clk),
      .reset    (reset),
      .clr      (state_chg),
      .inc      (acc0 | acc1),
      .at_limit (at_limit)
   );

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (req0 && req1) begin
               next_state = last ? OWN0 : OWN1;
            end else if (req0) begin
               next_state = OWN0;
            end else if (req1) begin
               next_state = OWN1;
            end
         end
         OWN0: begin
            if (!req0) begin
               next_state = req1 ? OWN1 : IDLE;
            end else if (at_limit && req1) begin
               next_state = OWN1;
            end
         end
         OWN1: begin
            if (!req1) begin
               next_state = req0 ? OWN0 : IDLE;
            end else if (at_limit && req0) begin
               next_state = OWN0;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Memory port is driven only while the owner actually requests.
   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_d  = '0;
      if (acc0) begin
         mem_we = we0;
         mem_a  = addr0;
         mem_d  = wdata0;
      end else if (acc1) begin
         mem_we = we1;
         mem_a  = addr1;
         mem_d  = wdata1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         last    <= 1'b1;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata   <= '0;
      end else begin
         state   <= next_state;
         gnt0    <= (next_state == OWN0);
         gnt1    <= (next_state == OWN1);
         rvalid0 <= acc0 & ~we0;
         rvalid1 <= acc1 & ~we1;
         if (next_state == OWN0) begin
            last <= 1'b0;
         end else if (next_state == OWN1) begin
            last <= 1'b1;
         end
         if ((acc0 & ~we0) | (acc1 & ~we1)) begin
            rdata <= mem_spo;
         end
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (acc0) begin
            cnt0 <= cnt0 + 1'b1;
         end
         if (acc1) begin
            cnt1 <= cnt1 + 1'b1;
         end
      end
   end

   assign acc_cnt0 = cnt0;
   assign acc_cnt1 = cnt1;
`else
   assign acc_cnt0 = '0;
   assign acc_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, cpu_stall;
   logic [31:0] rdata;
   logic        mem_we;
   logic [15:0] mem_a;
   logic [31:0] mem_d, mem_spo;
   logic [15:0] acc_cnt0, acc_cnt1;

   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;
   int n_acc0 = 0;
   int n_acc1 = 0;
   int n_we   = 0;

   mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rdata     (rdata),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .cpu_stall (cpu_stall),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_d     (mem_d),
      .mem_spo   (mem_spo),
      .acc_cnt0  (acc_cnt0),
      .acc_cnt1  (acc_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_spo = mem[mem_a[7:0]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_d;

   // Mid-cycle observers; inputs only change just after a rising edge.
   always @(negedge clk) begin
      if (gnt0 && req0) n_acc0++;
      if (gnt1 && req1) n_acc1++;
      if (mem_we) n_we++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset;
      reset = 0;
      idle_inputs();
      tick();
      tick();
      reset = 1;
   endtask

   task automatic test_reset;
      reset = 0;
      idle_inputs();
      tick();
      tick();
      total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_gnt got=%b%b want=00", gnt0, gnt1);
      end
      total++;
      if (rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_rdata got=%h want=0", rdata);
      end
      total++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl got=%b%b%b want=000", rvalid0, rvalid1, mem_we);
      end
      total++;
      if (acc_cnt0 !== 16'h0 || acc_cnt1 !== 16'h0) begin
         bad++;
         $display("FAIL reset_cnt got=%h/%h want=0/0", acc_cnt0, acc_cnt1);
      end
      reset = 1;
   endtask

   task automatic test_single_read;
      do_reset();
      mem[16] = 32'h1234ABCD;
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      tick();
      total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         bad++;
         $display("FAIL read_grant got=%b%b want=10", gnt0, gnt1);
      end
      total++;
      if (mem_a !== 16'h0010 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL read_addr got=%h/%b want=0010/0", mem_a, mem_we);
      end
      tick();
      total++;
      if (rdata !== 32'h1234ABCD || rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin
         bad++;
         $display("FAIL read_data got=%h/%b%b want=1234abcd/10",
                  rdata, rvalid0, rvalid1);
      end
      req0 = 0;
      tick();
      total++;
      if (gnt0 !== 1'b0) begin
         bad++;
         $display("FAIL read_drop got=%b want=0", gnt0);
      end
      tick();
   endtask

   task automatic test_tie;
      do_reset();
      req0 = 1; req1 = 1;
      tick();
      total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || cpu_stall !== 1'b0) begin
         bad++;
         $display("FAIL tie_first got=%b%b stall=%b want=10 stall=0",
                  gnt0, gnt1, cpu_stall);
      end
      req0 = 0; req1 = 0;
      tick();
      req0 = 1; req1 = 1;
      tick();
      total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || cpu_stall !== 1'b1) begin
         bad++;
         $display("FAIL tie_second got=%b%b stall=%b want=01 stall=1",
                  gnt0, gnt1, cpu_stall);
      end
      req0 = 0; req1 = 0;
      tick();
      tick();
   endtask

   task automatic test_burst_limit;
      int a0, a1, edges;
      bit seen;
      do_reset();
      a0 = n_acc0;
      req0 = 1; addr0 = 16'h0020;
      tick();
      tick();
      tick();
      req1 = 1; addr1 = 16'h0030;
      edges = 3;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         edges++;
         if (gnt1) seen = 1;
      end
      total++;
      if (!seen || edges !== 9 || n_acc0 - a0 !== 8) begin
         bad++;
         $display("FAIL burst_limit seen=%b edge=%0d acc0=%0d want edge=9 acc0=8",
                  seen, edges, n_acc0 - a0);
      end
      total++;
      if (cpu_stall !== 1'b1 || gnt0 !== 1'b0) begin
         bad++;
         $display("FAIL burst_stall got=%b gnt0=%b want=1 gnt0=0",
                  cpu_stall, gnt0);
      end
      a1 = n_acc1;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (gnt0) seen = 1;
      end
      total++;
      if (!seen || n_acc1 - a1 !== 8) begin
         bad++;
         $display("FAIL burst_back seen=%b acc1=%0d want=8", seen, n_acc1 - a1);
      end
      req0 = 0; req1 = 0;
      tick();
      tick();
   endtask

   task automatic test_write_read;
      int w;
      do_reset();
      mem[4] = 32'h0;
      w = n_we;
      req1 = 1; we1 = 1; addr1 = 16'h0004; wdata1 = 32'hDEADBEEF;
      tick();
      total++;
      if (gnt1 !== 1'b1 || mem_we !== 1'b1 || mem_a !== 16'h0004 ||
          mem_d !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL wr_issue got=%b/%b/%h/%h want=1/1/0004/deadbeef",
                  gnt1, mem_we, mem_a, mem_d);
      end
      tick();
      req1 = 0;
      req0 = 1; we0 = 0; addr0 = 16'h0004;
      #1;
      total++;
      if (mem_we !== 1'b0 || cpu_stall !== 1'b1) begin
         bad++;
         $display("FAIL wr_drop got=%b stall=%b want=0 stall=1", mem_we, cpu_stall);
      end
      tick();
      total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         bad++;
         $display("FAIL wr_handover got=%b%b want=10", gnt0, gnt1);
      end
      tick();
      total++;
      if (rdata !== 32'hDEADBEEF || rvalid0 !== 1'b1) begin
         bad++;
         $display("FAIL wr_readback got=%h/%b want=deadbeef/1", rdata, rvalid0);
      end
      req0 = 0;
      tick();
      tick();
      total++;
      if (n_we - w !== 1) begin
         bad++;
         $display("FAIL wr_we_cycles got=%0d want=1", n_we - w);
      end
   endtask

   task automatic test_burst_drop;
      int a0;
      do_reset();
      a0 = n_acc0;
      req0 = 1; req1 = 1; addr0 = 16'h0060; addr1 = 16'h0070;
      tick();
      repeat (7) tick();
      req0 = 0;
      tick();
      total++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || n_acc0 - a0 !== 7) begin
         bad++;
         $display("FAIL drop_switch got=%b%b acc0=%0d want=01 acc0=7",
                  gnt0, gnt1, n_acc0 - a0);
      end
      tick();
      total++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
         bad++;
         $display("FAIL drop_hold got=%b%b want=01", gnt0, gnt1);
      end
      req1 = 0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_burst;
      int w;
      do_reset();
      req1 = 1; we1 = 1; addr1 = 16'h0040; wdata1 = 32'hA5A5_0001;
      tick();
      tick();
      tick();
      reset = 0;
      tick();
      w = n_we;
      total++;
      if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || rvalid1 !== 1'b0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid got=%b%b/%b/%b want=00/0/0",
                  gnt0, gnt1, rvalid1, mem_we);
      end
      total++;
      if (acc_cnt0 !== 16'h0 || acc_cnt1 !== 16'h0) begin
         bad++;
         $display("FAIL rst_mid_cnt got=%h/%h want=0/0", acc_cnt0, acc_cnt1);
      end
      tick();
      total++;
      if (n_we - w !== 0) begin
         bad++;
         $display("FAIL rst_mid_we got=%0d want=0", n_we - w);
      end
      req1 = 0;
      reset = 1;
      tick();
   endtask

   task automatic test_stats;
      int a0, a1;
      do_reset();
      a0 = n_acc0;
      a1 = n_acc1;
      req0 = 1; we0 = 0; addr0 = 16'h0050;
      repeat (6) tick();
      req0 = 0;
      req1 = 1; we1 = 1; addr1 = 16'h0051; wdata1 = 32'h0000_0333;
      repeat (3) tick();
      total++;
      if (rvalid1 !== 1'b0) begin
         bad++;
         $display("FAIL stats_wr_rvalid got=%b want=0", rvalid1);
      end
      tick();
      req1 = 0;
      tick();
      total++;
      if (n_acc0 - a0 !== 5 || n_acc1 - a1 !== 3) begin
         bad++;
         $display("FAIL stats_seq got=%0d/%0d want=5/3", n_acc0 - a0, n_acc1 - a1);
      end
`ifdef MEM_ARB_STATS_EN
      total++;
      if (acc_cnt0 !== 16'd5 || acc_cnt1 !== 16'd3) begin
         bad++;
         $display("FAIL stats_cnt got=%0d/%0d want=5/3", acc_cnt0, acc_cnt1);
      end
`else
      total++;
      if (acc_cnt0 !== 16'd0 || acc_cnt1 !== 16'd0) begin
         bad++;
         $display("FAIL stats_cnt got=%0d/%0d want=0/0", acc_cnt0, acc_cnt1);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset = 0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_tie();
      test_burst_limit();
      test_write_read();
      test_burst_drop();
      test_reset_mid_burst();
      test_stats();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
